// File: rtl/mux8_to_1.sv
// mux8_to_1 -- registered 8-to-1 lane selector.
//
// On every rising clock edge with en high, lane sel of d is captured into y
// and y_valid is raised for the following cycle. With en low, y holds and
// y_valid drops. Because y is taken straight from a flop, glitches on d/sel
// never appear on the output.
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst_n    in   1          asynchronous active-low reset (clears y, y_valid)
//   en       in   1          capture enable
//   d        in   8*DATA_W   eight lanes, lane i = d[i*DATA_W +: DATA_W]
//   sel      in   3          lane index 0..7
//   y        out  DATA_W     registered selected lane
//   y_valid  out  1          high for the cycle after an enabled capture

// Simulation-side checker: a capture with an unknown lane index is flagged.
module mux8_to_1_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       en,
  input logic [2:0] sel
);

  a_sel_known: assert property (@(posedge clk) disable iff (!rst_n)
                                en |-> !$isunknown(sel))
    else $error("mux8_to_1: sel unknown during enabled capture");

endmodule

module mux8_to_1 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [8*DATA_W-1:0]   d,
  input  logic [2:0]            sel,
  output logic [DATA_W-1:0]     y,
  output logic                  y_valid
);

  logic [DATA_W-1:0] lane_s;
  logic [DATA_W-1:0] y_r;
  logic              y_valid_r;

  // Extract one DATA_W-wide lane from the packed lane vector.
  function automatic logic [DATA_W-1:0] lane_pick(
    input logic [8*DATA_W-1:0] vec,
    input logic [2:0]          idx
  );
    lane_pick = vec[32'(idx) * DATA_W +: DATA_W];
  endfunction

  // Combinational lane selection feeding the output register.
  always_comb begin
    lane_s = lane_pick(d, sel);
  end

  // Output register: capture on enable, hold otherwise; valid follows en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= '0;
      y_valid_r <= 1'b0;
    end else if (en) begin
      y_r       <= lane_s;
      y_valid_r <= 1'b1;
    end else begin
      y_r       <= y_r;
      y_valid_r <= 1'b0;
    end
  end

  assign y       = y_r;
  assign y_valid = y_valid_r;

  mux8_to_1_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel)
  );

endmodule

// File: tb/tb_mux8_to_1.sv
// Testbench for mux8_to_1: one 1-bit-lane instance and one 4-bit-lane
// instance share clock, reset, enable and select. A behavioural model
// (shift-and-mask of the lane vector, plus a last-value hold) predicts both.
module tb_mux8_to_1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  sel;
  logic [7:0]  d1;
  logic [31:0] d4;
  logic        y1;
  logic        v1;
  logic [3:0]  y4;
  logic        v4;

  int checks;
  int errors;

  // Reference model state.
  int unsigned exp_y1;
  int unsigned exp_y4;
  int unsigned exp_v;

  mux8_to_1 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d1), .sel(sel), .y(y1), .y_valid(v1)
  );

  mux8_to_1 #(.DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d4), .sel(sel), .y(y4), .y_valid(v4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic chk_all(input string tag);
    chk({tag, ".y1"}, {31'd0, y1}, exp_y1);
    chk({tag, ".v1"}, {31'd0, v1}, exp_v);
    chk({tag, ".y4"}, {28'd0, y4}, exp_y4);
    chk({tag, ".v4"}, {31'd0, v4}, exp_v);
  endtask

  // Advance one edge, update the model from the inputs sampled there, check.
  task automatic step(input string tag);
    int unsigned s;
    @(posedge clk);
    s = int'(sel);
    if (!rst_n) begin
      exp_y1 = 0; exp_y4 = 0; exp_v = 0;
    end else if (en) begin
      exp_y1 = (int'(d1) >> s) % 2;
      exp_y4 = (d4 >> (4 * s)) % 16;
      exp_v  = 1;
    end else begin
      exp_v  = 0;
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with all inputs active: outputs must be zero at once and stay so.
    rst_n = 1'b0; en = 1'b1; sel = 3'd7; d1 = 8'hFF; d4 = 32'hFFFF_FFFF;
    exp_y1 = 0; exp_y4 = 0; exp_v = 0;
    #1;
    chk_all("reset_now");
    repeat (3) step("reset_hold");
    rst_n = 1'b1;
    step("reset_release");
    chk("release_y1_is_1", {31'd0, y1}, 32'd1);

    // Sweep of alternating pattern.
    d1 = 8'b1010_1010;
    d4 = 32'h7654_3210;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step("sweep");
      chk("sweep_pattern", {31'd0, y1}, 32'(s % 2));
    end

    // Hold: capture a 1, then disable and change inputs.
    sel = 3'd1; d1 = 8'b1010_1010;
    step("hold_capture");
    en = 1'b0; sel = 3'd0; d1 = 8'h00; d4 = 32'h0;
    step("hold1");
    chk("hold_y1_stays_1", {31'd0, y1}, 32'd1);
    step("hold2");
    en = 1'b1;

    // Walking one.
    for (int k = 0; k < 8; k++) begin
      d1 = 8'(1 << k);
      sel = 3'(k);
      step("walk_hit");
      chk("walk_hit_is_1", {31'd0, y1}, 32'd1);
      sel = 3'((k + 1) % 8);
      step("walk_miss");
      chk("walk_miss_is_0", {31'd0, y1}, 32'd0);
    end

    // Mid-stream reset pulled between edges.
    d1 = 8'b1010_1010; d4 = 32'hFEDC_BA98;
    for (int s = 0; s < 4; s++) begin
      sel = 3'(s);
      step("pre_mid_reset");
    end
    #2;
    rst_n = 1'b0;
    exp_y1 = 0; exp_y4 = 0; exp_v = 0;
    #1;
    chk_all("mid_reset_async");
    step("mid_reset_low1");
    step("mid_reset_low2");
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step("post_mid_reset");
    end

    // Width case on the 4-bit instance.
    d4 = 32'h7654_3210;
    sel = 3'd5;
    step("width5");
    chk("width_sel5", {28'd0, y4}, 32'h5);
    sel = 3'd7;
    step("width7");
    chk("width_sel7", {28'd0, y4}, 32'h7);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      en  = ($urandom_range(3, 0) != 0);
      sel = 3'($urandom_range(7, 0));
      d1  = 8'($urandom);
      d4  = $urandom;
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux8_to_1.md
# mux8_to_1

Registered 8-to-1 selector. On each enabled rising clock edge it captures the data bit (or lane) of `d` addressed by `sel`. The result is presented on a registered output together with a valid flag. The block sits in datapaths where one of eight sources is steered onto a single line, and it must produce a glitch-free, clock-aligned output.

## Interface
Parameters:
- `DATA_W`, default 1: width of each of the eight input lanes and of `y`.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `en`  input  1: capture enable; when high, `d`/`sel` are sampled this edge.
- `d`  input  8*DATA_W: eight lanes; lane i = `d[i*DATA_W +: DATA_W]`. With DATA_W=1, lane i is bit `d[i]`.
- `sel`  input  3: lane index 0..7.
- `y`  output  DATA_W: registered selected lane.
- `y_valid`  output  1: high for the cycle after an enabled capture.

## Operation
- Selection: lane `sel` of `d` is selected. All 8 codes are legal; there is no out-of-range case.
- With `en`=1 at a rising edge:
  - `y` <= lane[`sel`].
  - `y_valid` <= 1.
- With `en`=0 at a rising edge:
  - `y` holds its value.
  - `y_valid` <= 0.
- `y` never changes between clock edges except on reset assertion. Combinational glitches on `d`/`sel` never reach `y`.
- `sel` containing X/Z with `en`=1 gives an unspecified `y`. A simulation-only assertion flags this case.
- `d`, `sel` and `en` must be stable within setup/hold of `clk`. No other input constraints apply.
- There is no internal state beyond the `y` and `y_valid` registers.

## Timing
- Reset:
  - `rst_n`=0 forces `y`=0 and `y_valid`=0 immediately, with no clock needed.
  - The outputs stay 0 while `rst_n` is low, regardless of `en`.
- Reset release:
  - Release is synchronized by the system.
  - The first rising edge with `rst_n`=1 and `en`=1 performs a normal capture.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on `y` after edge N and remain until the next enabled edge.
- Throughput: one selection per cycle. `en` may be held high continuously, giving a new `y` every cycle with `y_valid` held high.
- Simultaneous change of `d` and `sel` in the same cycle: the pair sampled at the edge determines `y`.
- Reset asserted mid-stream: any capture in flight is discarded, and the outputs go to 0 at once.

## Test plan
- Reset: assert `rst_n`=0 with `d`=8'hFF, `sel`=3'b111, `en`=1 -> `y`=0 and `y_valid`=0 immediately and through several clocks. Release -> `y`=1 after the next edge.
- Sweep: `d`=8'b10101010, `en`=1, `sel` stepped 000..111, one per cycle -> `y` = 0,1,0,1,0,1,0,1 one cycle after each `sel`, with `y_valid`=1 throughout.
- Hold: capture `sel`=3'b001 (`y`=1), then set `en`=0 and change `sel`=3'b000 and `d`=8'h00 -> `y` stays 1 and `y_valid`=0 from the next edge.
- Walking one: `d`=1<<k and `sel`=k for k=0..7 -> `y`=1. Same `d` with `sel`=(k+1)%8 -> `y`=0.
- Mid-operation reset: stream the sweep, pull `rst_n` low between edges -> `y` and `y_valid` drop to 0 asynchronously. After release the sweep resumes correctly.
- Width: DATA_W=4, `d`=32'h76543210, `sel`=3'b101 -> `y`=4'h5. `sel`=3'b111 -> `y`=4'h7.
